csel_add_pipe: RTL

Parametrised, pipelined carry-select adder/subtractor for the multiplier datapath's final-addition path. Splits a WIDTH-bit operand into WIDTH/BLK carry-select blocks. Each block precomputes sum and carry for carry-in 0 and carry-in 1, then selects one using the registered carry from the block below. One block resolves per pipeline stage, with a valid/ready handshake, add/subtract mode and signed-overflow detection.

---
 rtl/csel_add_pipe.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/csel_add_pipe.sv
// csel_add_pipe: pipelined carry-select adder/subtractor.
// The operand is split into NBLK = WIDTH/BLK blocks. Each pipeline stage
// resolves one block: both carry-in cases are precomputed and the carry
// registered by the previous stage selects between them. The whole pipe
// advances together under a single valid/ready handshake.
module csel_add_pipe #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int NBLK = WIDTH / BLK;

    // Pipeline registers: operands are carried forward so upper slices
    // are always taken from a register, never from a multi-stage wire.
    logic [WIDTH-1:0] a_q      [NBLK];
    logic [WIDTH-1:0] bb_q     [NBLK];
    logic [WIDTH-1:0] sum_q    [NBLK];
    logic [NBLK-1:0]  carry_q;
    logic [NBLK-1:0]  valid_q;
    logic             ovf_q;

    logic [WIDTH-1:0] a_d      [NBLK];
    logic [WIDTH-1:0] bb_d     [NBLK];
    logic [WIDTH-1:0] sum_d    [NBLK];
    logic [NBLK-1:0]  carry_d;
    logic [NBLK-1:0]  valid_d;
    logic             ovf_d;

    // Stage inputs and per-stage resolution results.
    logic [WIDTH-1:0] stg_a_s   [NBLK];
    logic [WIDTH-1:0] stg_bb_s  [NBLK];
    logic [WIDTH-1:0] stg_sum_s [NBLK];
    logic [NBLK-1:0]  stg_c_s;
    logic [BLK:0]     s0_s      [NBLK];
    logic [BLK:0]     s1_s      [NBLK];
    logic [WIDTH-1:0] res_sum_s [NBLK];
    logic [NBLK-1:0]  res_c_s;
    logic             res_ovf_s;
    logic             adv_s;

    // Whole pipe moves when the output slot is empty or being drained.
    assign adv_s    = out_ready | ~valid_q[NBLK-1];
    assign in_ready = adv_s;

    // Route stage inputs: stage 0 sees the (inverted for subtract) operands,
    // later stages see the registers of the stage below.
    always_comb begin
        stg_a_s[0]   = a;
        stg_bb_s[0]  = sub ? ~b : b;
        stg_c_s[0]   = sub ? ~cin : cin;
        stg_sum_s[0] = '0;
        for (int k = 1; k < NBLK; k++) begin
            stg_a_s[k]   = a_q[k-1];
            stg_bb_s[k]  = bb_q[k-1];
            stg_c_s[k]   = carry_q[k-1];
            stg_sum_s[k] = sum_q[k-1];
        end
    end

    // Carry-select resolution of block k in stage k.
    always_comb begin
        for (int k = 0; k < NBLK; k++) begin
            s0_s[k] = {1'b0, stg_a_s[k][k*BLK +: BLK]} + {1'b0, stg_bb_s[k][k*BLK +: BLK]};
            s1_s[k] = s0_s[k] + {{BLK{1'b0}}, 1'b1};
            res_sum_s[k] = stg_sum_s[k];
            if (stg_c_s[k]) begin
                res_sum_s[k][k*BLK +: BLK] = s1_s[k][BLK-1:0];
                res_c_s[k]                 = s1_s[k][BLK];
            end else begin
                res_sum_s[k][k*BLK +: BLK] = s0_s[k][BLK-1:0];
                res_c_s[k]                 = s0_s[k][BLK];
            end
        end
        // Carry into the MSB is a^b^s at that bit; overflow is it XOR carry out.
        res_ovf_s = stg_a_s[NBLK-1][WIDTH-1] ^ stg_bb_s[NBLK-1][WIDTH-1]
                  ^ res_sum_s[NBLK-1][WIDTH-1] ^ res_c_s[NBLK-1];
    end

    // Next-state: shift every stage on advance, otherwise hold.
    always_comb begin
        a_d     = a_q;
        bb_d    = bb_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (adv_s) begin
            valid_d[0] = in_valid;
            if (in_valid) begin
                a_d[0]     = stg_a_s[0];
                bb_d[0]    = stg_bb_s[0];
                sum_d[0]   = res_sum_s[0];
                carry_d[0] = res_c_s[0];
            end else begin
                a_d[0]     = a_q[0];
                bb_d[0]    = bb_q[0];
                sum_d[0]   = sum_q[0];
                carry_d[0] = carry_q[0];
            end
            for (int k = 1; k < NBLK; k++) begin
                valid_d[k] = valid_q[k-1];
                a_d[k]     = stg_a_s[k];
                bb_d[k]    = stg_bb_s[k];
                sum_d[k]   = res_sum_s[k];
                carry_d[k] = res_c_s[k];
            end
            ovf_d = res_ovf_s;
        end else begin
            valid_d = valid_q;
            ovf_d   = ovf_q;
        end
    end

    // State registers with synchronous reset that discards in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NBLK; k++) begin
                a_q[k]   <= '0;
                bb_q[k]  <= '0;
                sum_q[k] <= '0;
            end
            carry_q <= '0;
            valid_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            bb_q    <= bb_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum       = sum_q[NBLK-1];
    assign cout      = carry_q[NBLK-1];
    assign ovf       = ovf_q;
    assign out_valid = valid_q[NBLK-1];

endmodule
